// File: rtl/bf_prog_mem.sv
// Loadable brainfuck program memory: packs an ASCII byte stream into 3-bit opcodes and serves
// registered reads. Define BF_PROG_MEM_BRACKET_CHECK_EN to build the bracket-balance checker.
module bf_prog_mem #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  output logic              ld_ready,
  input  logic              ld_done,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [2:0]        code,
  output logic              code_valid,
  output logic              overrun,
  output logic [ADDR_W:0]   prog_len,
  output logic              prog_ready,
  output logic              err_full,
  output logic              err_unbal
);

  localparam int unsigned    IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DepthVal = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StLoad, StReady, StError} state_e;

  state_e     state_q;
  logic [2:0] mem [DEPTH];

  logic       is_cmd;
  logic [2:0] op;
  logic       accept;
  logic       store;
  logic       drop_full;
  logic       done_now;
  logic       full_d;
  logic       unbal_d;
  logic       rd_ovr;

  always_comb begin
    is_cmd = 1'b1;
    op     = 3'b111;
    unique case (ld_byte)
      8'h2B:   op = 3'b111;
      8'h2D:   op = 3'b110;
      8'h3E:   op = 3'b101;
      8'h3C:   op = 3'b100;
      8'h5B:   op = 3'b011;
      8'h5D:   op = 3'b010;
      8'h2E:   op = 3'b001;
      8'h2C:   op = 3'b000;
      default: is_cmd = 1'b0;
    endcase
  end

  // A start pulse takes priority over any byte or done presented in the same cycle.
  assign accept    = (state_q == StLoad) && ld_valid && !ld_start;
  assign store     = accept && is_cmd && (prog_len != DepthVal);
  assign drop_full = accept && is_cmd && (prog_len == DepthVal);
  assign done_now  = (state_q == StLoad) && ld_done && !ld_start;
  assign full_d    = err_full | drop_full;

`ifdef BF_PROG_MEM_BRACKET_CHECK_EN
  logic [ADDR_W:0] depth_q;
  logic [ADDR_W:0] depth_d;
  logic            unbal_now;
  logic            err_unbal_q;

  always_comb begin
    depth_d   = depth_q;
    unbal_now = 1'b0;
    if (store && (op == 3'b011)) begin
      depth_d = depth_q + 1'b1;
    end else if (store && (op == 3'b010)) begin
      if (depth_q == '0) unbal_now = 1'b1;
      else               depth_d   = depth_q - 1'b1;
    end
  end

  assign unbal_d   = err_unbal_q | unbal_now | (done_now && (depth_d != '0));
  assign err_unbal = err_unbal_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_q     <= '0;
      err_unbal_q <= 1'b0;
    end else if (ld_start) begin
      depth_q     <= '0;
      err_unbal_q <= 1'b0;
    end else if (state_q == StLoad) begin
      depth_q     <= depth_d;
      err_unbal_q <= unbal_d;
    end
  end
`else
  assign unbal_d   = 1'b0;
  assign err_unbal = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      prog_len <= '0;
      err_full <= 1'b0;
    end else if (ld_start) begin
      state_q  <= StLoad;
      prog_len <= '0;
      err_full <= 1'b0;
    end else begin
      case (state_q)
        StLoad: begin
          if (store) prog_len <= prog_len + 1'b1;
          err_full <= full_d;
          if (ld_done) state_q <= (!full_d && !unbal_d) ? StReady : StError;
        end
        default: ;
      endcase
    end
  end

  assign ld_ready   = (state_q == StLoad);
  assign prog_ready = (state_q == StReady);

  always_ff @(posedge clk) begin
    if (store) mem[prog_len[IdxW-1:0]] <= op;
  end

  assign rd_ovr = (state_q != StReady) || ({1'b0, rd_addr} >= prog_len);

  // Overrun guarantees rd_addr < prog_len <= DEPTH whenever the array is actually read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code       <= 3'b111;
      overrun    <= 1'b1;
      code_valid <= 1'b0;
    end else begin
      code_valid <= rd_en;
      if (rd_en) begin
        overrun <= rd_ovr;
        code    <= rd_ovr ? 3'b111 : mem[rd_addr[IdxW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_bf_prog_mem.sv
// Scoreboarded bench for bf_prog_mem: a full-size instance for reads and a DEPTH=4 instance
// for the capacity limit, both fed from the same load port.
module tb_bf_prog_mem;

  logic        clk;
  logic        rst;
  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_done;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [2:0]  rd_addr_s;

  logic        ld_ready,   ld_ready_s;
  logic [2:0]  code,       code_s;
  logic        code_valid, code_valid_s;
  logic        overrun,    overrun_s;
  logic [10:0] prog_len;
  logic [3:0]  prog_len_s;
  logic        prog_ready, prog_ready_s;
  logic        err_full,   err_full_s;
  logic        err_unbal,  err_unbal_s;

  typedef struct packed {
    logic [2:0] c;
    logic       o;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  assign rd_addr_s = rd_addr[2:0];

  bf_prog_mem #(.ADDR_W(10), .DEPTH(1024)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .ld_start   (ld_start),
    .ld_valid   (ld_valid),
    .ld_byte    (ld_byte),
    .ld_ready   (ld_ready),
    .ld_done    (ld_done),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .code       (code),
    .code_valid (code_valid),
    .overrun    (overrun),
    .prog_len   (prog_len),
    .prog_ready (prog_ready),
    .err_full   (err_full),
    .err_unbal  (err_unbal)
  );

  bf_prog_mem #(.ADDR_W(3), .DEPTH(4)) u_small (
    .clk        (clk),
    .rst        (rst),
    .ld_start   (ld_start),
    .ld_valid   (ld_valid),
    .ld_byte    (ld_byte),
    .ld_ready   (ld_ready_s),
    .ld_done    (ld_done),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr_s),
    .code       (code_s),
    .code_valid (code_valid_s),
    .overrun    (overrun_s),
    .prog_len   (prog_len_s),
    .prog_ready (prog_ready_s),
    .err_full   (err_full_s),
    .err_unbal  (err_unbal_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog(input string s, input bit done);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      ld_valid = 1'b1;
      ld_byte  = s[i];
      tick();
    end
    ld_valid = 1'b0;
    if (done) begin
      ld_done = 1'b1;
      tick();
      ld_done = 1'b0;
    end
  endtask

  // Holds rd_en high across consecutive calls; result is checked on the following falling edge.
  task automatic issue_read(input logic [9:0] addr, input logic [2:0] c, input logic o);
    exp_t e;
    rd_en   = 1'b1;
    rd_addr = addr;
    exp_q.push_back('{c: c, o: o});
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (code_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_valid addr=%0d: code_valid=%b required 1", addr, code_valid);
    end else begin
      e = exp_q.pop_front();
      if ({code, overrun} !== {e.c, e.o}) begin
        miscompares++;
        $display("FAIL rd_data addr=%0d: code=%b overrun=%b required code=%b overrun=%b",
                 addr, code, overrun, e.c, e.o);
      end
    end
  endtask

  task automatic end_reads();
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #10;
    vectors++;
    if ({code, overrun, code_valid} !== 5'b11110) begin
      miscompares++;
      $display("FAIL reset_rd: code=%b ovr=%b valid=%b required 111 1 0",
               code, overrun, code_valid);
    end
    vectors++;
    if ({ld_ready, prog_ready, err_full, err_unbal} !== 4'b0000 || prog_len !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_ld: ready=%b prdy=%b ef=%b eu=%b len=%0d required all 0",
               ld_ready, prog_ready, err_full, err_unbal, prog_len);
    end
    rst = 1'b0;
    tick();
    issue_read(10'd0, 3'b111, 1'b1);
    end_reads();
  endtask

  task automatic test_load();
    load_prog("+>a[-].", 1'b1);
    vectors++;
    if (prog_len !== 11'd6 || prog_ready !== 1'b1 || err_full !== 1'b0) begin
      miscompares++;
      $display("FAIL load_status: len=%0d rdy=%b ef=%b required 6 1 0",
               prog_len, prog_ready, err_full);
    end
    issue_read(10'd0, 3'b111, 1'b0);
    issue_read(10'd1, 3'b101, 1'b0);
    issue_read(10'd2, 3'b011, 1'b0);
    issue_read(10'd3, 3'b110, 1'b0);
    issue_read(10'd4, 3'b010, 1'b0);
    issue_read(10'd5, 3'b001, 1'b0);
    issue_read(10'd6, 3'b111, 1'b1);
    issue_read(10'd1, 3'b101, 1'b0);
    end_reads();
    vectors++;
    if (code !== 3'b101 || code_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_hold: code=%b valid=%b required 101 0", code, code_valid);
    end
    // Reload overwrites the first locations with the remaining two opcodes.
    load_prog("<,x", 1'b1);
    vectors++;
    if (prog_len !== 11'd2 || prog_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reload_status: len=%0d rdy=%b required 2 1", prog_len, prog_ready);
    end
    issue_read(10'd0, 3'b100, 1'b0);
    issue_read(10'd1, 3'b000, 1'b0);
    issue_read(10'd2, 3'b111, 1'b1);
    end_reads();
  endtask

  task automatic test_full();
    load_prog("+++++", 1'b0);
    vectors++;
    if (prog_len_s !== 4'd4 || err_full_s !== 1'b1 || prog_len !== 11'd5 || err_full !== 1'b0) begin
      miscompares++;
      $display("FAIL full_len: small len=%0d ef=%b big len=%0d ef=%b required 4 1 5 0",
               prog_len_s, err_full_s, prog_len, err_full);
    end
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    vectors++;
    if (prog_ready_s !== 1'b0 || ld_ready_s !== 1'b0 || prog_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL full_done: small rdy=%b ldrdy=%b big rdy=%b required 0 0 1",
               prog_ready_s, ld_ready_s, prog_ready);
    end
    load_prog("+", 1'b1);
    vectors++;
    if (prog_ready_s !== 1'b1 || err_full_s !== 1'b0 || prog_len_s !== 4'd1) begin
      miscompares++;
      $display("FAIL full_recover: rdy=%b ef=%b len=%0d required 1 0 1",
               prog_ready_s, err_full_s, prog_len_s);
    end
  endtask

  task automatic test_brackets();
`ifdef BF_PROG_MEM_BRACKET_CHECK_EN
    load_prog("]", 1'b0);
    vectors++;
    if (err_unbal !== 1'b1 || ld_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL unbal_close: eu=%b ldrdy=%b required 1 1", err_unbal, ld_ready);
    end
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    vectors++;
    if (prog_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL unbal_close_done: rdy=%b required 0", prog_ready);
    end
    load_prog("[[", 1'b1);
    vectors++;
    if (err_unbal !== 1'b1 || prog_ready !== 1'b0 || ld_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL unbal_open: eu=%b rdy=%b ldrdy=%b required 1 0 0",
               err_unbal, prog_ready, ld_ready);
    end
`else
    load_prog("[[", 1'b1);
    vectors++;
    if (err_unbal !== 1'b0 || prog_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL nocheck_open: eu=%b rdy=%b required 0 1", err_unbal, prog_ready);
    end
`endif
    load_prog("[]", 1'b1);
    vectors++;
    if (prog_ready !== 1'b1 || err_unbal !== 1'b0 || err_full !== 1'b0 || prog_len !== 11'd2) begin
      miscompares++;
      $display("FAIL balanced: rdy=%b eu=%b ef=%b len=%0d required 1 0 0 2",
               prog_ready, err_unbal, err_full, prog_len);
    end
    issue_read(10'd0, 3'b011, 1'b0);
    issue_read(10'd1, 3'b010, 1'b0);
    end_reads();
  endtask

  task automatic test_simultaneous();
    ld_start = 1'b1;
    ld_valid = 1'b1;
    ld_byte  = 8'h2B;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b0;
    vectors++;
    if (prog_len !== 11'd0 || ld_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL start_wins: len=%0d ldrdy=%b required 0 1", prog_len, ld_ready);
    end
    ld_valid = 1'b1;
    ld_byte  = 8'h2D;
    ld_done  = 1'b1;
    tick();
    vectors++;
    if (prog_len !== 11'd1 || prog_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL done_with_byte: len=%0d rdy=%b required 1 1", prog_len, prog_ready);
    end
    // Both are ignored outside LOAD.
    ld_byte = 8'h2B;
    tick();
    ld_valid = 1'b0;
    ld_done  = 1'b0;
    vectors++;
    if (prog_len !== 11'd1 || prog_ready !== 1'b1 || ld_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_ready: len=%0d rdy=%b ldrdy=%b required 1 1 0",
               prog_len, prog_ready, ld_ready);
    end
    issue_read(10'd0, 3'b110, 1'b0);
    issue_read(10'd1, 3'b111, 1'b1);
    end_reads();
  endtask

  task automatic test_reset_midload();
    load_prog("+++", 1'b0);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (prog_len !== 11'd0 || ld_ready !== 1'b0 || prog_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midload_rst: len=%0d ldrdy=%b rdy=%b required 0 0 0",
               prog_len, ld_ready, prog_ready);
    end
    rst = 1'b0;
    tick();
    issue_read(10'd0, 3'b111, 1'b1);
    end_reads();
  endtask

  initial begin
    rst         = 1'b0;
    ld_start    = 1'b0;
    ld_valid    = 1'b0;
    ld_byte     = 8'h00;
    ld_done     = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = '0;
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_load();
    test_full();
    test_brackets();
    test_simultaneous();
    test_reset_midload();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
